pwm_deadtime_gen: RTL and testbench

Downstream stage of the MPPT controller. Consumes the controller's 8-bit duty-cycle word and produces a complementary high-side/low-side gate-drive pair for the converter half-bridge, with programmable dead time. Duty updates are double-buffered and take effect only at a period boundary, so no glitched or truncated pulse is ever produced.

---
 rtl/pwm_deadtime_gen.sv | 226 ++++++++++++++++++++++
 tb/tb_pwm_deadtime_gen.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime_gen.sv
// -----------------------------------------------------------------------------
// pwm_deadtime_gen
//
// Purpose:
//   Turns the MPPT controller's 8-bit duty word into a complementary
//   high-side / low-side gate-drive pair with programmable dead time.
//   The duty word is clamped, captured into a pending register and copied
//   into the active register only at a period boundary (or continuously
//   while stopped), so a running period is never truncated or glitched.
//
// Parameters:
//   DT_CYCLES  dead time in clk cycles before either gate turns on (1..15)
//   DUTY_MIN   lower clamp for the incoming duty word
//   DUTY_MAX   upper clamp for the incoming duty word (DUTY_MIN <= DUTY_MAX)
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   en            run enable; 0 forces both gates off
//   duty_in       requested duty word
//   duty_valid    1-cycle strobe, duty_in captured when high
//   gate_hi       high-side gate drive (registered)
//   gate_lo       low-side gate drive (registered)
//   period_start  registered pulse flagging a cycle that ran with cnt==0
//   duty_applied  duty value currently in use
//
// Optional feature (macro FAULT_IN_EN):
//   fault          fault input, latches on the next edge
//   fault_clr      strobe that clears the latched fault (fault has priority)
//   fault_latched  registered fault flag; while set both gates stay off
// -----------------------------------------------------------------------------
module pwm_deadtime_gen #(
  parameter int unsigned DT_CYCLES = 4,
  parameter int unsigned DUTY_MIN  = 0,
  parameter int unsigned DUTY_MAX  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] duty_in,
  input  logic       duty_valid,
`ifdef FAULT_IN_EN
  input  logic       fault,
  input  logic       fault_clr,
  output logic       fault_latched,
`endif
  output logic       gate_hi,
  output logic       gate_lo,
  output logic       period_start,
  output logic [7:0] duty_applied
);

  localparam logic [7:0] LP_MIN     = 8'(DUTY_MIN);
  localparam logic [7:0] LP_MAX     = 8'(DUTY_MAX);
  localparam logic [3:0] LP_DT_LOAD = 4'(DT_CYCLES - 1);
  localparam logic [7:0] LP_DUTY_RST = 8'd128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_DT_H,
    ST_HI,
    ST_DT_L
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_dtc;
  logic [3:0] w_dtc_next;
  logic [7:0] r_cnt;
  logic [7:0] r_pending;
  logic [7:0] r_active;
  logic       r_gate_hi;
  logic       r_gate_lo;
  logic       r_period_start;
  logic [7:0] w_clamped;
  logic       w_run;
  logic       w_raw;

  // ---------------------------------------------------------------------------
  // Run qualifier: en, optionally vetoed by a pending or latched fault.
  // The live fault input is included so the gates drop on the very next edge.
  // ---------------------------------------------------------------------------
`ifdef FAULT_IN_EN
  logic r_fault_latched;
  logic w_hold;

  assign w_hold = fault | r_fault_latched;
  assign w_run  = en & ~w_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault_latched <= 1'b0;
    end else if (fault) begin
      r_fault_latched <= 1'b1;
    end else if (fault_clr) begin
      r_fault_latched <= 1'b0;
    end
  end

  assign fault_latched = r_fault_latched;
`else
  assign w_run = en;
`endif

  // ---------------------------------------------------------------------------
  // Clamp. Using <= / >= keeps the comparisons meaningful for the default
  // limits 0 and 255 while giving the same result as min(max()).
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_clamped = duty_in;
    if (duty_in <= LP_MIN) begin
      w_clamped = LP_MIN;
    end else if (duty_in >= LP_MAX) begin
      w_clamped = LP_MAX;
    end
  end

  // Raw PWM: high for the first 'active' cycles of each 256-cycle period.
  assign w_raw = w_run & (r_cnt < r_active);

  // ---------------------------------------------------------------------------
  // Dead-time FSM, next-state logic.
  // The abort paths in the dead-time states return to the gate that was on
  // before, because the opposite gate never switched on and needs no gap.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_dtc_next   = r_dtc;
    if (!w_run) begin
      w_state_next = ST_IDLE;
      w_dtc_next   = 4'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_next = ST_LO;
        end
        ST_LO: begin
          if (w_raw) begin
            w_state_next = ST_DT_H;
            w_dtc_next   = LP_DT_LOAD;
          end
        end
        ST_DT_H: begin
          if (!w_raw) begin
            w_state_next = ST_LO;
          end else if (r_dtc == 4'd0) begin
            w_state_next = ST_HI;
          end else begin
            w_dtc_next = r_dtc - 4'd1;
          end
        end
        ST_HI: begin
          if (!w_raw) begin
            w_state_next = ST_DT_L;
            w_dtc_next   = LP_DT_LOAD;
          end
        end
        ST_DT_L: begin
          if (w_raw) begin
            w_state_next = ST_HI;
          end else if (r_dtc == 4'd0) begin
            w_state_next = ST_LO;
          end else begin
            w_dtc_next = r_dtc - 4'd1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_dtc_next   = 4'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, counter, duty buffers and registered outputs.
  // Gates are decoded from the next state so each is a single flop driven by
  // a one-hot-exclusive compare; they can never be high together.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state        <= ST_IDLE;
      r_dtc          <= 4'd0;
      r_cnt          <= 8'd0;
      r_pending      <= LP_DUTY_RST;
      r_active       <= LP_DUTY_RST;
      r_gate_hi      <= 1'b0;
      r_gate_lo      <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_dtc   <= w_dtc_next;

      if (duty_valid) begin
        r_pending <= w_clamped;
      end

      if (w_run) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= 8'd0;
      end

      // A strobe arriving in the load cycle bypasses pending so it is not
      // lost for a whole period.
      if (!w_run || (r_cnt == 8'd255)) begin
        r_active <= duty_valid ? w_clamped : r_pending;
      end

      r_gate_hi      <= (w_state_next == ST_HI);
      r_gate_lo      <= (w_state_next == ST_LO);
      r_period_start <= w_run & (r_cnt == 8'd0);
    end
  end

  assign gate_hi      = r_gate_hi;
  assign gate_lo      = r_gate_lo;
  assign period_start = r_period_start;
  assign duty_applied = r_active;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_deadtime_gen
//
// Drives two instances from the same stimulus: one with default clamp limits
// and one with DUTY_MIN=10 / DUTY_MAX=240. Expected per-period gate counts are
// queued when the duty stimulus is chosen and compared once the period has
// been observed. Outputs are sampled and inputs driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_pwm_deadtime_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] duty_in;
  logic       duty_valid;

  logic       d_hi, d_lo, d_ps;
  logic [7:0] d_duty;
  logic       c_hi, c_lo, c_ps;
  logic [7:0] c_duty;
`ifdef FAULT_IN_EN
  logic       fault;
  logic       fault_clr;
  logic       d_fl, c_fl;
`endif

  always #5 clk = ~clk;

  pwm_deadtime_gen #(.DT_CYCLES(4), .DUTY_MIN(0), .DUTY_MAX(255)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
`ifdef FAULT_IN_EN
    .fault        (fault),
    .fault_clr    (fault_clr),
    .fault_latched(d_fl),
`endif
    .gate_hi      (d_hi),
    .gate_lo      (d_lo),
    .period_start (d_ps),
    .duty_applied (d_duty)
  );

  pwm_deadtime_gen #(.DT_CYCLES(4), .DUTY_MIN(10), .DUTY_MAX(240)) u_dut_clamp (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
`ifdef FAULT_IN_EN
    .fault        (fault),
    .fault_clr    (fault_clr),
    .fault_latched(c_fl),
`endif
    .gate_hi      (c_hi),
    .gate_lo      (c_lo),
    .period_start (c_ps),
    .duty_applied (c_duty)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int overlap  = 0;
  int tb_cnt   = 0;

  typedef struct {
    string tag;
    int    exp;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", got, -1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, got, e.exp);
    end
  endtask

  // Gates of either instance high together, counted over the whole run.
  always @(negedge clk) begin
    if ((d_hi && d_lo) || (c_hi && c_lo)) overlap++;
  end

  task automatic step();
    @(negedge clk);
    tb_cnt = (tb_cnt + 1) % 256;
  endtask

  // period_start seen at a sample means the counter now reads 1.
  task automatic sync_ps();
    bit found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      step();
      if (d_ps) begin
        found  = 1'b1;
        tb_cnt = 1;
      end
    end
    if (!found) check("sync_timeout", 0, 1);
  endtask

  task automatic goto_cnt(input int n);
    for (int k = 0; k < 300 && tb_cnt != n; k++) step();
  endtask

  // Observes one full period starting at the current (period_start) sample.
  task automatic measure_period();
    int dh = 0, dl = 0, db = 0, dp = 0, ch = 0, cl = 0;
    for (int k = 0; k < 256; k++) begin
      if (k > 0) step();
      dh += int'(d_hi);
      dl += int'(d_lo);
      db += int'(d_hi & d_lo);
      dp += int'(d_ps);
      ch += int'(c_hi);
      cl += int'(c_lo);
    end
    sb_pop(dh);
    sb_pop(dl);
    sb_pop(db);
    sb_pop(dp);
    sb_pop(ch);
    sb_pop(cl);
  endtask

  task automatic expect_period(input string name, input int dh, input int dl,
                               input int ch, input int cl);
    sb_push({name, "_d_hi"}, dh);
    sb_push({name, "_d_lo"}, dl);
    sb_push({name, "_d_both"}, 0);
    sb_push({name, "_d_ps"}, 1);
    sb_push({name, "_c_hi"}, ch);
    sb_push({name, "_c_lo"}, cl);
  endtask

  task automatic strobe(input logic [7:0] d);
    duty_in    = d;
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    duty_in    = 8'd0;
    duty_valid = 1'b0;
`ifdef FAULT_IN_EN
    fault      = 1'b0;
    fault_clr  = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_hi",      int'(d_hi), 0);
    check("rst_lo",      int'(d_lo), 0);
    check("rst_ps",      int'(d_ps), 0);
    check("rst_duty",    int'(d_duty), 128);
    check("rst_duty_c",  int'(c_duty), 128);

    // Enable: first enabled cycle ran with cnt==0
    rst = 1'b0;
    en  = 1'b1;
    step();
    tb_cnt = 1;
    check("en_ps", int'(d_ps), 1);
    check("en_lo", int'(d_lo), 1);

    // Default duty 128: hi 5..128, lo 133..255 plus 0, 4-cycle gaps
    sync_ps();
    check("t1_duty", int'(d_duty), 128);
    expect_period("t1", 124, 124, 124, 124);
    measure_period();

    // Strobe 64 mid-period: current period untouched, next one uses 64
    goto_cnt(100);
    strobe(8'd64);
    goto_cnt(200);
    check("t2_hold", int'(d_duty), 128);
    sync_ps();
    check("t2_duty", int'(d_duty), 64);
    expect_period("t2", 60, 188, 60, 188);
    measure_period();

    // Duty 2: DT_H aborts, gate_lo drops for 2 cycles; clamp instance uses 10
    step();
    strobe(8'd2);
    sync_ps();
    check("t3_duty",   int'(d_duty), 2);
    check("t3_duty_c", int'(c_duty), 10);
    expect_period("t3", 0, 254, 6, 242);
    measure_period();

    // Clamping: 255 -> 240 at the boundary, then 3 -> 10 via the cnt=255 bypass
    goto_cnt(100);
    strobe(8'd255);
    goto_cnt(255);
    check("t4_pre",   int'(d_duty), 2);
    check("t4_pre_c", int'(c_duty), 10);
    step();
    check("t4_max",   int'(d_duty), 255);
    check("t4_max_c", int'(c_duty), 240);
    sync_ps();
    expect_period("t4", 251, 0, 236, 12);
    measure_period();
    goto_cnt(255);
    check("t4_pre2_c", int'(c_duty), 240);
    strobe(8'd3);
    check("t4_byp",   int'(d_duty), 3);
    check("t4_byp_c", int'(c_duty), 10);

    // en dropped while in HI, duty follows while stopped, then re-enable
    strobe(8'd128);
    goto_cnt(255);
    step();
    goto_cnt(50);
    check("t5_in_hi", int'(d_hi), 1);
    en = 1'b0;
    step();
    check("t5_off_hi", int'(d_hi), 0);
    check("t5_off_lo", int'(d_lo), 0);
    check("t5_off_ps", int'(d_ps), 0);
    strobe(8'd200);
    check("t5_idle_duty", int'(d_duty), 200);
    check("t5_idle_lo",   int'(d_lo), 0);
    en = 1'b1;
    step();
    tb_cnt = 1;
    check("t5_re_ps", int'(d_ps), 1);
    check("t5_re_lo", int'(d_lo), 1);
    check("t5_re_hi", int'(d_hi), 0);

    // Reset mid-period
    goto_cnt(60);
    rst = 1'b1;
    step();
    check("t5_rst_hi",     int'(d_hi), 0);
    check("t5_rst_lo",     int'(d_lo), 0);
    check("t5_rst_ps",     int'(d_ps), 0);
    check("t5_rst_duty",   int'(d_duty), 128);
    check("t5_rst_duty_c", int'(c_duty), 128);
    rst = 1'b0;

`ifdef FAULT_IN_EN
    // Fault during HI, hold while latched, resume after clear
    step();
    tb_cnt = 1;
    check("t6_start_ps", int'(d_ps), 1);
    goto_cnt(50);
    check("t6_in_hi", int'(d_hi), 1);
    fault = 1'b1;
    step();
    fault = 1'b0;
    check("t6_f_hi", int'(d_hi), 0);
    check("t6_f_fl", int'(d_fl), 1);
    repeat (5) step();
    check("t6_hold_hi", int'(d_hi), 0);
    check("t6_hold_lo", int'(d_lo), 0);
    check("t6_hold_fl", int'(d_fl), 1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("t6_clr_fl", int'(d_fl), 0);
    check("t6_clr_lo", int'(d_lo), 0);
    step();
    check("t6_res_ps", int'(d_ps), 1);
    check("t6_res_lo", int'(d_lo), 1);
`endif

    check("no_overlap", overlap, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
